shownumber_seq: RTL and testbench
=================================

Name: shownumber_seq

Overview:
Sequential, parametrised successor to the combinational decimal display driver. It converts a NUM_W-bit unsigned binary value to DIGITS decimal digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock, instead of using divide/modulo chains. Results drive 7-segment displays with optional leading-zero blanking and overflow indication. A valid/ready handshake is used on input and a done pulse on output. It sits between the measurement/count logic and the board HEX displays.

Parameters:
NUM_W, 33, width of input binary value (1..64)
DIGITS, 6, number of decimal digits / 7-seg displays driven (1..10)
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always shown); 0 = show all zeros
ACTIVE_LOW, 1, 1 = segment outputs active-low (board HEX); 0 = active-high

Ports:
i_Clk  in  1  system clock; all logic on rising edge
i_Rst  in  1  reset, asynchronous, active-high
i_Valid  in  1  request: i_Num is valid this cycle
o_Ready  out  1  block can accept a request (IDLE only)
i_Num  in  NUM_W  unsigned binary value, sampled when i_Valid & o_Ready
o_Seg  out  7*DIGITS  segment bus; digit k at [7k+6:7k], bit order gfedcba; digit 0 = least significant
o_Bcd  out  4*DIGITS  registered BCD digits of last completed conversion; digit k at [4k+3:4k]
o_Ovf  out  1  last completed value was >= 10^DIGITS
o_Done  out  1  one-cycle pulse when o_Seg/o_Bcd/o_Ovf update

Behaviour:
- Reset (async assert, clock-synchronous effect thereafter): state IDLE, o_Ready=1, o_Done=0, o_Ovf=0, o_Bcd=0, all digits blank (all-ones if ACTIVE_LOW, else zero). Reset mid-conversion aborts it and blanks the display; no o_Done.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE: o_Ready=1. On i_Valid=1: latch i_Num into shift reg, clear BCD work reg and sticky overflow, load bit counter = NUM_W, go to SHIFT. i_Valid=0: stay.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1. The bit shifted out of the top nibble ORs into sticky overflow. Decrement counter; after NUM_W shift cycles, go to LOAD. o_Ready=0.
- LOAD (1 cycle): register o_Bcd, o_Ovf and o_Seg; o_Done=1; o_Ready=0; next state IDLE.
- Latency: accept at cycle 0 -> o_Done high at cycle NUM_W+1 with outputs valid that same cycle; min request spacing NUM_W+2 cycles.
- i_Valid while o_Ready=0 is ignored; no queueing and no error flag. The display holds the previous result until LOAD.
- Overflow: if sticky=1, every digit shows dash (segment g only); o_Bcd holds value mod 10^DIGITS.
- Blanking (BLANK_LZ=1, no overflow): digit k blanks when k>0 and all digits k..DIGITS-1 are zero. Value 0 shows "0" on digit 0 only.
- Encoding (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, dash=40, blank=00. ACTIVE_LOW inverts all 7 bits. BCD nibble >9 cannot occur; the encoder maps it to blank.
- Width: BCD work reg is 4*DIGITS bits; the counter is clog2(NUM_W+1) bits. No truncation of i_Num.

Decomposition:
- Package shownumber_pkg: segment constants (SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK, active-high form), state enum type, function for counter width.
- One sub-module, seg7_enc: combinational 4-bit BCD + blank + dash + ACTIVE_LOW -> 7 segments, generated DIGITS times. Double-dabble datapath and FSM stay in shownumber_seq.

Test Plan:
(defaults NUM_W=33, DIGITS=6, BLANK_LZ=1, ACTIVE_LOW=1)
- Reset: assert i_Rst asynchronously between edges -> immediately o_Seg all 1s, o_Ready=1, o_Done=0, o_Ovf=0, o_Bcd=0.
- i_Num=123456 accepted at cycle 0 -> o_Done only at cycle 34. Digits 5..0 = 79,24,30,19,12,02; o_Bcd=0x123456, o_Ovf=0; o_Ready back to 1 at cycle 35.
- i_Num=42 -> digits 5..2 = 7F, digit1=19, digit0=24. Then i_Num=0 -> digit0=40, digits 5..1=7F. With BLANK_LZ=0, i_Num=42 -> digits 5..2 = 40.
- i_Num=1000000 and i_Num=2^33-1 -> o_Ovf=1, all six digits = 3F (dash). For 1000000, o_Bcd=0x000000.
- Busy-drop: accept 999999, then hold i_Valid=1 with i_Num=7 for cycles 1..33 -> single o_Done, display 999999 (all 10). i_Num=7 is accepted at cycle 35 -> shows 7 (78) at cycle 69.
- Reset at cycle 10 of a conversion of 555 -> display blank, no o_Done. After release, request 8 -> digit0=00, others 7F.

Source files
------------

// File: rtl/shownumber_pkg.sv
// Shared constants and types for the sequential decimal display driver.
package shownumber_pkg;

  // Active-high segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } state_e;

  // Bits needed to hold a count from n down to 0.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shownumber_seq_seg7_enc.sv
// One 7-segment digit: BCD nibble plus blank/dash overrides, optional inversion.
module seg7_enc
  import shownumber_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  logic [6:0] seg_ah;

  // Dash wins over blank, blank wins over the digit; nibbles above 9 show blank.
  always_comb begin
    // NOTE: default assignment first so every path drives seg_ah and no latch is inferred.
    seg_ah = SEG_BLANK;
    if (i_dash) begin
      seg_ah = SEG_DASH;
    end else if (!i_blank) begin
      for (int i = 0; i < 10; i++) begin
        if (i_bcd == 4'(i)) seg_ah = SEG_DIGIT[i];
      end
    end
  end

  assign o_seg = ACTIVE_LOW ? ~seg_ah : seg_ah;

endmodule

// File: rtl/shownumber_seq.sv
// Binary to decimal 7-segment driver using a one-bit-per-clock double-dabble engine.
module shownumber_seq
  import shownumber_pkg::*;
#(
  parameter int NUM_W      = 33,
  parameter int DIGITS     = 6,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [NUM_W-1:0]      i_Num,
  output logic [7*DIGITS-1:0]   o_Seg,
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic                  o_Ovf,
  output logic                  o_Done
);

  localparam int CNT_W = cnt_width(NUM_W);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  state_e                state_q, state_d;
  logic [NUM_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  sticky_q, sticky_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
  logic                  ovf_q, ovf_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d;

  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_shift;
  logic [NUM_W-1:0]      bin_shift;
  logic                  shift_out;
  logic                  ovf_next;
  logic [DIGITS-1:0]     blank;
  logic [7*DIGITS-1:0]   seg_enc;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    {shift_out, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};
    ovf_next = sticky_q | shift_out;
  end

  // Leading-zero blanking on the final BCD value; digit 0 is never blanked.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (bcd_shift[4*k +: 4] == 4'd0);
      blank[k]   = BLANK_LZ && (k != 0) && zero_above;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_enc
    seg7_enc #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
      .i_bcd   (bcd_shift[4*k +: 4]),
      .i_blank (blank[k]),
      .i_dash  (ovf_next),
      .o_seg   (seg_enc[7*k +: 7])
    );
  end

  // Next-state logic: accept in IDLE, shift NUM_W times, then a one-cycle LOAD.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    seg_d     = seg_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Valid) begin
          bin_d    = i_Num;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(NUM_W);
          ready_d  = 1'b0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_d    = bin_shift;
        bcd_d    = bcd_shift;
        sticky_d = ovf_next;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Outputs are captured on the edge into LOAD so they are valid with o_Done.
          state_d   = ST_LOAD;
          done_d    = 1'b1;
          bcd_out_d = bcd_shift;
          ovf_d     = ovf_next;
          seg_d     = seg_enc;
        end
      end
      ST_LOAD: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the display and aborts any conversion.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
      seg_q     <= {DIGITS{SEG_OFF}};
    end else begin
      // NOTE: non-blocking so every register samples the values from before this edge.
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
      seg_q     <= seg_d;
    end
  end

  assign o_Ready = ready_q;
  assign o_Done  = done_q;
  assign o_Bcd   = bcd_out_q;
  assign o_Ovf   = ovf_q;
  assign o_Seg   = seg_q;

endmodule

// File: tb/tb_shownumber_seq.sv
// Directed bench for shownumber_seq (defaults plus a BLANK_LZ=0 twin on the same stimulus).
module tb_shownumber_seq;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [32:0] i_num;
  logic        o_ready, o_done, o_ovf;
  logic [41:0] o_seg;
  logic [23:0] o_bcd;
  logic        o_ready2, o_done2, o_ovf2;
  logic [41:0] o_seg2;
  logic [23:0] o_bcd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shownumber_seq u_dut (
    .i_Clk(clk), .i_Rst(i_rst), .i_Valid(i_valid), .o_Ready(o_ready),
    .i_Num(i_num), .o_Seg(o_seg), .o_Bcd(o_bcd), .o_Ovf(o_ovf), .o_Done(o_done)
  );

  shownumber_seq #(.BLANK_LZ(1'b0)) u_dut_nb (
    .i_Clk(clk), .i_Rst(i_rst), .i_Valid(i_valid), .o_Ready(o_ready2),
    .i_Num(i_num), .o_Seg(o_seg2), .o_Bcd(o_bcd2), .o_Ovf(o_ovf2), .o_Done(o_done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at the next falling edge; returns in cycle 1 of the conversion.
  task automatic start(input logic [32:0] num);
    @(negedge clk);
    i_valid = 1'b1;
    i_num   = num;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle number where o_Done is first seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_DASH  = {6{7'h3F}};

  initial begin
    int cyc;
    int ndone;
    int first_done;
    int second_done;

    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_num   = '0;

    // Asynchronous reset between clock edges.
    #2 i_rst = 1'b1;
    #1;
    check("rst_seg",   o_seg,   ALL_BLANK);
    check("rst_ready", o_ready, 1);
    check("rst_done",  o_done,  0);
    check("rst_ovf",   o_ovf,   0);
    check("rst_bcd",   o_bcd,   0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    // 123456: latency, digits, BCD, ready return.
    start(33'd123456);
    check("busy_ready", o_ready, 0);
    check("busy_hold",  o_seg,   ALL_BLANK);
    wait_done(cyc);
    check("lat_123456", cyc, 34);
    check("seg_123456", o_seg, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    check("bcd_123456", o_bcd, 24'h123456);
    check("ovf_123456", o_ovf, 0);
    @(negedge clk);
    check("ready_35",   o_ready, 1);
    check("done_35",    o_done,  0);

    // 42 with and without leading-zero blanking.
    start(33'd42);
    wait_done(cyc);
    check("seg_42",    o_seg,  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
    check("seg_42_nb", o_seg2, {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});

    // Zero keeps digit 0 visible.
    start(33'd0);
    wait_done(cyc);
    check("seg_0",    o_seg,  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("seg_0_nb", o_seg2, {6{7'h40}});
    check("bcd_0",    o_bcd,  0);

    // Overflow boundary and maximum input.
    start(33'd1000000);
    wait_done(cyc);
    check("ovf_1e6", o_ovf, 1);
    check("seg_1e6", o_seg, ALL_DASH);
    check("bcd_1e6", o_bcd, 0);

    start(33'h1_FFFF_FFFF);
    wait_done(cyc);
    check("ovf_max", o_ovf, 1);
    check("seg_max", o_seg, ALL_DASH);
    check("bcd_max", o_bcd, 24'h934591);

    // Busy-drop: valid held high during the conversion of 999999.
    @(negedge clk);
    i_valid     = 1'b1;
    i_num       = 33'd999999;
    ndone       = 0;
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1)  i_num = 33'd7;
      if (c == 36) i_valid = 1'b0;
      if (o_done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (c == 34) begin
        check("seg_999999", o_seg, {6{7'h10}});
        check("bcd_999999", o_bcd, 24'h999999);
        check("ovf_999999", o_ovf, 0);
      end
      if (c == 35) check("busy_ready_35", o_ready, 1);
      if (c == 69) check("seg_7", o_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});
    end
    check("busy_first_done",  first_done,  34);
    check("busy_second_done", second_done, 69);
    check("busy_done_count",  ndone,       2);

    // Reset in the middle of a conversion of 555.
    start(33'd555);
    repeat (9) @(negedge clk);
    #2 i_rst = 1'b1;
    #1;
    check("abort_seg",   o_seg,   ALL_BLANK);
    check("abort_ready", o_ready, 1);
    check("abort_bcd",   o_bcd,   0);
    @(negedge clk);
    i_rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_blank",   o_seg, ALL_BLANK);

    start(33'd8);
    wait_done(cyc);
    check("lat_8", cyc, 34);
    check("seg_8", o_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
